rsa_mmio_responder: RTL and testbench



---
 rtl/rsa_mmio_responder_pkg.sv | 39 +++
 rtl/rsa_mmio_responder_if.sv | 12 +
 rtl/rsa_mmio_responder_modmul.sv | 74 +++++++
 rtl/rsa_mmio_responder.sv | 246 ++++++++++++++++++++++++
 tb/tb_rsa_mmio_responder.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rsa_mmio_responder_pkg.sv
// Shared definitions for the RSA MMIO responder: register map, STATUS bits,
// FSM state encodings and small bus helpers.
package rsa_pkg;

    localparam logic [2:0] OFS_BASE   = 3'd0;
    localparam logic [2:0] OFS_EXP    = 3'd1;
    localparam logic [2:0] OFS_MOD    = 3'd2;
    localparam logic [2:0] OFS_CTRL   = 3'd3;
    localparam logic [2:0] OFS_STATUS = 3'd4;
    localparam logic [2:0] OFS_RESULT = 3'd5;

    localparam int unsigned ST_BUSY = 0;
    localparam int unsigned ST_DONE = 1;
    localparam int unsigned ST_ERR  = 2;

    typedef enum logic [1:0] {E_IDLE, E_SQR, E_MUL, E_DONE} eng_state_e;
    typedef enum logic [1:0] {B_IDLE, B_RESP, B_WAIT} bus_state_e;

    function automatic logic [31:0] merge_lanes(input logic [31:0] old,
                                                input logic [31:0] wd,
                                                input logic [3:0]  be);
        logic [31:0] r;
        r = old;
        for (int unsigned l = 0; l < 4; l++) begin
            if (be[l]) r[8*l +: 8] = wd[8*l +: 8];
        end
        return r;
    endfunction

    function automatic logic [5:0] msb_index(input logic [31:0] v);
        logic [5:0] idx;
        idx = '0;
        for (int unsigned k = 0; k < 32; k++) begin
            if (v[k]) idx = 6'(k);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rsa_mmio_responder_if.sv
// Core-to-target RSA port: request held until a one-cycle ack.
interface rsa_mmio_responder_if;
    logic        rsa_en;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  we;
    logic [31:0] rdata;
    logic        ack;

    modport master (output rsa_en, addr, wdata, we, input rdata, ack);
    modport slave  (input rsa_en, addr, wdata, we, output rdata, ack);
endinterface

// File: rtl/rsa_mmio_responder_modmul.sv
// Blakley interleaved modular multiplier: one load cycle, then WIDTH iterations.
module rsa_modmul #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] m_i,
    output logic [WIDTH-1:0] p_o,
    output logic             done_o
);
    localparam int unsigned PW = WIDTH + 2;

    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, m_q, m_d, p_q, p_d;
    logic [5:0]       cnt_q, cnt_d;
    logic             run_q, run_d, done_q, done_d;
    logic [PW-1:0]    acc;

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        m_d    = m_q;
        p_d    = p_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        done_d = 1'b0;
        // 2P + b < 3M, so two conditional subtractions always land in [0, M)
        acc = {1'b0, p_q, 1'b0} + (a_q[WIDTH-1] ? {2'b00, b_q} : '0);
        if (acc >= {2'b00, m_q}) acc = acc - {2'b00, m_q};
        if (acc >= {2'b00, m_q}) acc = acc - {2'b00, m_q};
        if (start_i) begin
            a_d   = a_i;
            b_d   = b_i;
            m_d   = m_i;
            p_d   = '0;
            cnt_d = 6'(WIDTH - 1);
            run_d = 1'b1;
        end else if (run_q) begin
            p_d   = acc[WIDTH-1:0];
            a_d   = a_q << 1;
            cnt_d = cnt_q - 6'd1;
            if (cnt_q == '0) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            m_q    <= '0;
            p_q    <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            m_q    <= m_d;
            p_q    <= p_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    assign p_o    = p_q;
    assign done_o = done_q;

endmodule

// File: rtl/rsa_mmio_responder.sv
// RSA bus target: bus FSM, register bank and left-to-right square-and-multiply
// sequencer driving a shared Blakley multiplier.
module rsa_mmio_responder
    import rsa_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned OFS_BITS = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    rsa_mmio_responder_if.slave  bus,
    output logic                 done_irq_o
);
    bus_state_e       bus_q, bus_d;
    eng_state_e       eng_q, eng_d;
    logic             ack_q, ack_d;
    logic [31:0]      rdata_q, rdata_d, rd_val;
    logic [WIDTH-1:0] base_q, base_d, exp_q, exp_d, mod_q, mod_d;
    logic [WIDTH-1:0] result_q, result_d, r_q, r_d;
    logic [WIDTH-1:0] eb_q, ee_q, em_q;
    logic             busy_q, busy_d, done_q, done_d, err_q, err_d, irq_q, irq_d;
    logic [5:0]       i_q, i_d;
    logic             kick_q, kick_d;

    logic             mm_start, mm_done;
    logic [WIDTH-1:0] mm_a, mm_b, mm_p;

    logic [OFS_BITS-1:0] ofs;
    logic [2:0]          idx;
    logic                is_read, wr_acc, start, start_err, start_ok, fin, exp_bit;
    logic                unused_addr_bits;

    assign ofs              = bus.addr[OFS_BITS-1:0];
    assign idx              = ofs[4:2];
    assign unused_addr_bits = ^{bus.addr[31:OFS_BITS], ofs[1:0]};
    assign is_read          = (bus.we == 4'b0000);
    assign fin              = (eng_q == E_DONE);
    assign wr_acc           = (bus_q == B_IDLE) && bus.rsa_en && !is_read && !busy_q;
    assign start            = wr_acc && (idx == OFS_CTRL) && bus.we[0] && bus.wdata[0];
    assign start_err        = (mod_q <= WIDTH'(1)) || (base_q >= mod_q);
    assign start_ok         = start && !start_err;
    assign exp_bit          = (ee_q & (WIDTH'(1) << i_q)) != '0;

    rsa_modmul #(.WIDTH(WIDTH)) u_modmul (
        .clk     (clk),
        .rst     (rst),
        .start_i (mm_start),
        .a_i     (mm_a),
        .b_i     (mm_b),
        .m_i     (em_q),
        .p_o     (mm_p),
        .done_o  (mm_done)
    );

    // STATUS forwards a finishing engine so a read in the E_DONE cycle sees done=1
    always_comb begin
        rd_val = '0;
        unique case (idx)
            OFS_BASE:   rd_val = 32'(base_q);
            OFS_EXP:    rd_val = 32'(exp_q);
            OFS_MOD:    rd_val = 32'(mod_q);
            OFS_STATUS: begin
                rd_val[ST_ERR]  = err_q;
                rd_val[ST_DONE] = done_q | fin;
                rd_val[ST_BUSY] = busy_q & ~fin;
            end
            OFS_RESULT: rd_val = 32'(result_q);
            default:    rd_val = '0;
        endcase
    end

    always_comb begin
        bus_d   = bus_q;
        ack_d   = 1'b0;
        rdata_d = '0;
        unique case (bus_q)
            B_IDLE: begin
                if (bus.rsa_en) begin
                    if (is_read && (idx == OFS_RESULT) && busy_q) begin
                        bus_d = B_WAIT;
                    end else begin
                        bus_d   = B_RESP;
                        ack_d   = 1'b1;
                        rdata_d = is_read ? rd_val : '0;
                    end
                end
            end
            B_RESP: bus_d = B_IDLE;
            B_WAIT: begin
                if (!busy_q) begin
                    bus_d   = B_RESP;
                    ack_d   = 1'b1;
                    rdata_d = 32'(result_q);
                end
            end
            default: bus_d = B_IDLE;
        endcase
    end

    always_comb begin
        base_d = base_q;
        exp_d  = exp_q;
        mod_d  = mod_q;
        if (wr_acc) begin
            unique case (idx)
                OFS_BASE: base_d = WIDTH'(merge_lanes(32'(base_q), bus.wdata, bus.we));
                OFS_EXP:  exp_d  = WIDTH'(merge_lanes(32'(exp_q), bus.wdata, bus.we));
                OFS_MOD:  mod_d  = WIDTH'(merge_lanes(32'(mod_q), bus.wdata, bus.we));
                default:  ;
            endcase
        end
    end

    always_comb begin
        busy_d   = busy_q;
        done_d   = done_q;
        err_d    = err_q;
        result_d = result_q;
        irq_d    = 1'b0;
        if (start) begin
            done_d = start_err;
            err_d  = start_err;
            if (start_err) begin
                result_d = '0;
                irq_d    = 1'b1;
            end else begin
                busy_d = 1'b1;
            end
        end
        if (fin) begin
            busy_d   = 1'b0;
            done_d   = 1'b1;
            result_d = r_q;
            irq_d    = 1'b1;
        end
    end

    // Each multiply is issued in the cycle the previous one completes, using its product directly
    always_comb begin
        eng_d    = eng_q;
        r_d      = r_q;
        i_d      = i_q;
        kick_d   = 1'b0;
        mm_start = 1'b0;
        mm_a     = r_q;
        mm_b     = r_q;
        unique case (eng_q)
            E_IDLE: begin
                if (start_ok) begin
                    r_d = WIDTH'(1);
                    i_d = msb_index(32'(exp_q));
                    if (exp_q == '0) begin
                        eng_d = E_DONE;
                    end else begin
                        eng_d  = E_SQR;
                        kick_d = 1'b1;
                    end
                end
            end
            E_SQR: begin
                if (kick_q) begin
                    mm_start = 1'b1;
                end else if (mm_done) begin
                    r_d  = mm_p;
                    mm_a = mm_p;
                    if (exp_bit) begin
                        eng_d    = E_MUL;
                        mm_start = 1'b1;
                        mm_b     = eb_q;
                    end else if (i_q == '0) begin
                        eng_d = E_DONE;
                    end else begin
                        i_d      = i_q - 6'd1;
                        mm_start = 1'b1;
                        mm_b     = mm_p;
                    end
                end
            end
            E_MUL: begin
                if (mm_done) begin
                    r_d  = mm_p;
                    mm_a = mm_p;
                    mm_b = mm_p;
                    if (i_q == '0) begin
                        eng_d = E_DONE;
                    end else begin
                        i_d      = i_q - 6'd1;
                        eng_d    = E_SQR;
                        mm_start = 1'b1;
                    end
                end
            end
            E_DONE:  eng_d = E_IDLE;
            default: eng_d = E_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_q    <= B_IDLE;
            eng_q    <= E_IDLE;
            ack_q    <= 1'b0;
            rdata_q  <= '0;
            base_q   <= '0;
            exp_q    <= '0;
            mod_q    <= '0;
            result_q <= '0;
            r_q      <= '0;
            eb_q     <= '0;
            ee_q     <= '0;
            em_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            irq_q    <= 1'b0;
            i_q      <= '0;
            kick_q   <= 1'b0;
        end else begin
            bus_q    <= bus_d;
            eng_q    <= eng_d;
            ack_q    <= ack_d;
            rdata_q  <= rdata_d;
            base_q   <= base_d;
            exp_q    <= exp_d;
            mod_q    <= mod_d;
            result_q <= result_d;
            r_q      <= r_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            irq_q    <= irq_d;
            i_q      <= i_d;
            kick_q   <= kick_d;
            if (start_ok) begin
                eb_q <= base_q;
                ee_q <= exp_q;
                em_q <= mod_q;
            end
        end
    end

    assign bus.ack    = ack_q;
    assign bus.rdata  = rdata_q;
    assign done_irq_o = irq_q;

endmodule

// File: tb/tb_rsa_mmio_responder.sv
// Directed and randomized checks of the RSA MMIO responder against a
// arithmetic reference model of the register map and modular exponentiation.
module tb_rsa_mmio_responder;
    import rsa_pkg::*;

    localparam int unsigned W       = 32;
    localparam int          LAT_MAX = 2 * W * (W + 1) + 3;

    logic clk = 1'b0;
    logic rst;
    logic done_irq;

    rsa_mmio_responder_if bus ();

    rsa_mmio_responder #(.WIDTH(W), .OFS_BITS(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .done_irq_o (done_irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int irq_cnt = 0;
    int irq_cyc = -1;
    int ack_cyc = 0;

    logic [31:0] m_base, m_exp, m_mod, m_result;
    logic        m_done, m_err, m_busy;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (done_irq === 1'b1) begin
        irq_cnt++;
        irq_cyc = cyc;
    end

    function automatic logic [31:0] ref_modexp(input logic [31:0] b, input logic [31:0] e,
                                               input logic [31:0] m);
        longint unsigned r, bb, mm;
        bb = b;
        mm = m;
        r  = 1 % mm;
        for (int k = 31; k >= 0; k--) begin
            r = (r * r) % mm;
            if (e[k]) r = (r * bb) % mm;
        end
        return 32'(r);
    endfunction

    function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [31:0] d,
                                              input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int l = 0; l < 4; l++) if (be[l]) r[8*l +: 8] = d[8*l +: 8];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] reg_addr(input logic [2:0] idx);
        logic [31:0] a;
        a = $urandom;
        a[4:2] = idx;
        return a;
    endfunction

    task automatic xfer(input logic [2:0] idx, input logic [31:0] d, input logic [3:0] w,
                        output logic [31:0] rd, output int lat);
        @(negedge clk);
        bus.rsa_en = 1'b1;
        bus.addr   = reg_addr(idx);
        bus.wdata  = d;
        bus.we     = w;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (bus.ack !== 1'b1 && lat < 5000);
        rd      = bus.rdata;
        ack_cyc = cyc;
        chk("ack", 32'(bus.ack), 32'd1);
        bus.rsa_en = 1'b0;
        bus.we     = 4'b0000;
    endtask

    task automatic wr(input logic [2:0] idx, input logic [31:0] d, input logic [3:0] w);
        logic [31:0] rd;
        int lat;
        xfer(idx, d, w, rd, lat);
        if (!m_busy) begin
            if (idx == OFS_BASE) m_base = ref_merge(m_base, d, w);
            if (idx == OFS_EXP)  m_exp  = ref_merge(m_exp, d, w);
            if (idx == OFS_MOD)  m_mod  = ref_merge(m_mod, d, w);
        end
    endtask

    task automatic rd_reg(input logic [2:0] idx, output logic [31:0] rd);
        int lat;
        xfer(idx, $urandom, 4'b0000, rd, lat);
    endtask

    function automatic logic [31:0] m_status();
        return {29'd0, m_err, m_done, m_busy};
    endfunction

    task automatic start_op();
        logic err;
        wr(OFS_CTRL, 32'h1, 4'b0001);
        err      = (m_mod < 2) || (m_base >= m_mod);
        m_err    = err;
        m_done   = err;
        m_busy   = !err;
        m_result = err ? 32'd0 : ref_modexp(m_base, m_exp, m_mod);
    endtask

    task automatic wait_done();
        logic [31:0] s;
        int n;
        n = 0;
        do begin
            rd_reg(OFS_STATUS, s);
            n++;
        end while (s[ST_DONE] !== 1'b1 && n < 2000);
        chk("done_poll", 32'(s[ST_DONE]), 32'd1);
        m_busy = 1'b0;
        m_done = 1'b1;
    endtask

    task automatic run_and_check(input string tag);
        logic [31:0] rd;
        int irq0, sack;
        irq0 = irq_cnt;
        start_op();
        sack = ack_cyc;
        wait_done();
        rd_reg(OFS_STATUS, rd);
        chk({tag, "_status"}, rd, m_status());
        rd_reg(OFS_RESULT, rd);
        chk({tag, "_result"}, rd, m_result);
        chk({tag, "_irq_cnt"}, 32'(irq_cnt - irq0), 32'd1);
        chk({tag, "_latency"}, 32'((irq_cyc - sack) <= LAT_MAX), 32'd1);
    endtask

    task automatic model_reset();
        m_base = '0; m_exp = '0; m_mod = '0; m_result = '0;
        m_done = 1'b0; m_err = 1'b0; m_busy = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] d;
        logic [3:0]  w;
        logic [2:0]  ri;
        int lat, irq0, sack;

        rst = 1'b1;
        bus.rsa_en = 1'b0; bus.addr = '0; bus.wdata = '0; bus.we = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // reset state
        chk("rst_ack", 32'(bus.ack), 32'd0);
        chk("rst_rdata", bus.rdata, 32'd0);
        chk("rst_irq", 32'(done_irq), 32'd0);
        rd_reg(OFS_STATUS, rd); chk("rst_status", rd, 32'd0);
        rd_reg(OFS_RESULT, rd); chk("rst_result", rd, 32'd0);
        rd_reg(OFS_BASE, rd);   chk("rst_base", rd, 32'd0);

        // 4^13 mod 497
        wr(OFS_BASE, 32'd4, 4'hF); wr(OFS_EXP, 32'd13, 4'hF); wr(OFS_MOD, 32'd497, 4'hF);
        run_and_check("t1");

        // EXP = 0 completes within three cycles
        wr(OFS_BASE, 32'd7, 4'hF); wr(OFS_EXP, 32'd0, 4'hF); wr(OFS_MOD, 32'd13, 4'hF);
        irq0 = irq_cnt;
        start_op();
        sack = ack_cyc;
        repeat (4) @(negedge clk);
        chk("t2_exp0_irq", 32'(irq_cnt - irq0), 32'd1);
        chk("t2_exp0_fast", 32'((irq_cyc - sack) <= 3), 32'd1);
        rd_reg(OFS_RESULT, rd); chk("t2_exp0_result", rd, 32'd1);
        m_busy = 1'b0; m_done = 1'b1;
        rd_reg(OFS_STATUS, rd); chk("t2_exp0_status", rd, m_status());

        wr(OFS_MOD, 32'd1, 4'hF);
        run_and_check("t2_mod1");
        wr(OFS_BASE, 32'd5, 4'hF); wr(OFS_MOD, 32'd5, 4'hF);
        run_and_check("t2_base_eq_mod");

        // RESULT read stalls while busy
        wr(OFS_BASE, 32'd3, 4'hF); wr(OFS_EXP, 32'd200, 4'hF); wr(OFS_MOD, 32'd1000, 4'hF);
        start_op();
        xfer(OFS_RESULT, 32'd0, 4'b0000, rd, lat);
        m_busy = 1'b0; m_done = 1'b1;
        chk("t3_stalled", 32'(lat > 1), 32'd1);
        chk("t3_rdata", rd, m_result);
        chk("t3_ack_after_done", 32'(ack_cyc), 32'(irq_cyc + 1));

        // back-to-back STATUS reads with rsa_en held
        @(negedge clk);
        bus.rsa_en = 1'b1; bus.addr = reg_addr(OFS_STATUS); bus.we = 4'b0000;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            chk("t4_ack_pattern", 32'(bus.ack), 32'(k % 2));
            chk("t4_rdata", bus.rdata, (k % 2 == 1) ? m_status() : 32'd0);
        end
        bus.rsa_en = 1'b0;

        // byte-lane writes
        wr(OFS_BASE, 32'd0, 4'hF);
        wr(OFS_BASE, 32'h00AB_0000, 4'b0100);
        rd_reg(OFS_BASE, rd); chk("t5_sb_lane2", rd, m_base);
        for (int k = 0; k < 8; k++) begin
            ri = 3'($urandom_range(0, 2));
            d  = $urandom;
            w  = 4'($urandom_range(1, 15));
            wr(ri, d, w);
            rd_reg(ri, rd);
            chk("t5_lanes", rd, (ri == OFS_BASE) ? m_base : (ri == OFS_EXP) ? m_exp : m_mod);
        end
        rd_reg(3'd6, rd); chk("t5_unmapped6", rd, 32'd0);
        rd_reg(OFS_CTRL, rd); chk("t5_ctrl_reads0", rd, 32'd0);

        // writes while busy are discarded
        wr(OFS_BASE, 32'd2, 4'hF); wr(OFS_EXP, 32'hFFFF_FFFF, 4'hF);
        wr(OFS_MOD, 32'hFFFF_FFF1, 4'hF);
        start_op();
        wr(OFS_MOD, 32'd5, 4'hF);
        wr(OFS_CTRL, 32'h1, 4'hF);
        rd_reg(OFS_MOD, rd); chk("t5_mod_busy", rd, m_mod);
        rd_reg(OFS_STATUS, rd); chk("t5_status_busy", rd, m_status());
        wait_done();
        rd_reg(OFS_RESULT, rd); chk("t5_result", rd, m_result);

        // reset mid-operation
        wr(OFS_BASE, 32'd2, 4'hF); wr(OFS_EXP, 32'hFFFF_FFFF, 4'hF);
        wr(OFS_MOD, 32'd1000003, 4'hF);
        start_op();
        repeat (200) @(negedge clk);
        irq0 = irq_cnt;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        rd_reg(OFS_STATUS, rd); chk("t6_status", rd, 32'd0);
        rd_reg(OFS_RESULT, rd); chk("t6_result", rd, 32'd0);
        rd_reg(OFS_MOD, rd);    chk("t6_mod", rd, 32'd0);
        repeat (100) @(negedge clk);
        chk("t6_no_irq", 32'(irq_cnt - irq0), 32'd0);
        wr(OFS_BASE, 32'd2, 4'hF); wr(OFS_EXP, 32'd10, 4'hF); wr(OFS_MOD, 32'd1023, 4'hF);
        run_and_check("t6_after_rst");

        // randomized operands
        for (int t = 0; t < 6; t++) begin
            d = $urandom;
            if (d < 2) d = 32'd3;
            wr(OFS_MOD, d, 4'hF);
            wr(OFS_BASE, (t == 5) ? d : ($urandom % d), 4'hF);
            wr(OFS_EXP, $urandom >> $urandom_range(0, 31), 4'hF);
            run_and_check("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
